coin_acceptor: RTL and testbench

Front-end stage that feeds the vending-machine FSM. Takes two raw, bouncy, asynchronous coin-sensor lines (5-unit and 10-unit slots) and synchronizes and debounces each one. Each accepted coin becomes a single-cycle 4-bit coin code on coin_code, in exactly the encoding the vending FSM decodes. Coins that arrive together are serialized, and overflowed or jammed inputs are flagged.

---
 rtl/vm_pkg.sv | 7 +
 rtl/coin_debounce.sv | 44 ++++
 rtl/coin_acceptor.sv | 89 ++++++++
 tb/tb_coin_acceptor.sv | 123 ++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// vm_pkg: coin codes and output FSM states shared with the vending FSM
package vm_pkg;
  localparam logic [3:0] COIN_NONE = 4'b0000;
  localparam logic [3:0] COIN_5    = 4'b0101;
  localparam logic [3:0] COIN_10   = 4'b1010;
  typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;
endpackage

// File: rtl/coin_debounce.sv
// coin_debounce: 2-FF sync, debounce filter, rise pulse and sticky jam detector for one coin slot
module coin_debounce #(
  parameter int DEB_CYCLES = 4,
  parameter int JAM_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic rise,
  output logic jam
);
  localparam int DW = $clog2(DEB_CYCLES);
  localparam int JW = $clog2(JAM_CYCLES + 1);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES - 1);
  localparam logic [JW-1:0] JAM_MAX = JW'(JAM_CYCLES);
  logic s1, s2, filt, filt_d;
  logic [DW-1:0] cnt;
  logic [JW-1:0] jcnt;
  assign rise = filt & ~filt_d;
  // synchronize, then let filt follow s2 only after it has differed for DEB_CYCLES cycles
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      filt   <= 1'b0;
      filt_d <= 1'b0;
      cnt    <= '0;
    end else begin
      s1     <= raw;
      s2     <= s1;
      filt_d <= filt;
      cnt    <= (s2 == filt || cnt == DEB_MAX) ? '0 : cnt + 1'b1;
      if (s2 != filt && cnt == DEB_MAX) filt <= s2;
    end
  // saturating high-time counter; jam latches once filt stays high past JAM_CYCLES
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      jcnt <= '0;
      jam  <= 1'b0;
    end else begin
      jcnt <= !filt ? '0 : (jcnt == JAM_MAX ? jcnt : jcnt + 1'b1);
      if (filt && jcnt == JAM_MAX) jam <= 1'b1;
    end
endmodule

// File: rtl/coin_acceptor.sv
// coin_acceptor: debounces two coin slots and serializes accepted coins into single-cycle codes
module coin_acceptor
  import vm_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int GAP_CYCLES = 1,
  parameter int JAM_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin5_raw,
  input  logic       coin10_raw,
  output logic [3:0] coin_code,
  output logic       coin_valid,
  output logic       reject,
  output logic [1:0] jam,
  output logic       busy
);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(GAP_CYCLES - 1);
  state_t state, state_n;
  logic rise5, rise10, set5, set10, clr5, clr10;
  logic pend5, pend10, pend5_n, pend10_n, rej_n, busy_n;
  logic [3:0] code_n;
  logic [GW-1:0] gcnt, gcnt_n;
  coin_debounce #(.DEB_CYCLES(DEB_CYCLES), .JAM_CYCLES(JAM_CYCLES)) u_deb5 (
    .clk(clk), .reset(reset), .raw(coin5_raw), .rise(rise5), .jam(jam[0])
  );
  coin_debounce #(.DEB_CYCLES(DEB_CYCLES), .JAM_CYCLES(JAM_CYCLES)) u_deb10 (
    .clk(clk), .reset(reset), .raw(coin10_raw), .rise(rise10), .jam(jam[1])
  );
  assign set5  = rise5 & ~jam[0];
  assign set10 = rise10 & ~jam[1];
  // output FSM next state, pending-flag bookkeeping and overflow detection
  always_comb begin
    state_n = state;
    code_n  = COIN_NONE;
    gcnt_n  = gcnt;
    clr5    = 1'b0;
    clr10   = 1'b0;
    case (state)
      IDLE: begin
        if (pend5) begin
          code_n  = COIN_5;
          clr5    = 1'b1;
          state_n = EMIT;
        end else if (pend10) begin
          code_n  = COIN_10;
          clr10   = 1'b1;
          state_n = EMIT;
        end
      end
      EMIT: begin
        state_n = GAP;
        gcnt_n  = '0;
      end
      GAP: begin
        state_n = (gcnt == GAP_MAX) ? IDLE : GAP;
        gcnt_n  = gcnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
    pend5_n  = (pend5 & ~clr5) | set5;
    pend10_n = (pend10 & ~clr10) | set10;
    rej_n    = (set5 & pend5 & ~clr5) | (set10 & pend10 & ~clr10);
    busy_n   = (state_n != IDLE) | pend5_n | pend10_n;
  end
  // state, pending flags and registered outputs
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= IDLE;
      gcnt       <= '0;
      pend5      <= 1'b0;
      pend10     <= 1'b0;
      coin_code  <= COIN_NONE;
      coin_valid <= 1'b0;
      reject     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      gcnt       <= gcnt_n;
      pend5      <= pend5_n;
      pend10     <= pend10_n;
      coin_code  <= code_n;
      coin_valid <= code_n != COIN_NONE;
      reject     <= rej_n;
      busy       <= busy_n;
    end
endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: directed-vector bench for coin_acceptor
module tb_coin_acceptor;
  logic clk = 1'b0, reset = 1'b0;
  logic c5 = 1'b0, c10 = 1'b0, o5 = 1'b0, o10 = 1'b0;
  logic [3:0] code, ocode;
  logic valid, ovalid, rej, orej, busy, obusy;
  logic [1:0] jam, ojam;
  int vecs = 0, errs = 0, n5, n10;
  always #5 clk = ~clk;
  coin_acceptor dut (
    .clk(clk), .reset(reset), .coin5_raw(c5), .coin10_raw(c10),
    .coin_code(code), .coin_valid(valid), .reject(rej), .jam(jam), .busy(busy)
  );
  coin_acceptor #(.GAP_CYCLES(20)) dut_ov (
    .clk(clk), .reset(reset), .coin5_raw(o5), .coin10_raw(o10),
    .coin_code(ocode), .coin_valid(ovalid), .reject(orej), .jam(ojam), .busy(obusy)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    c5 = 0; c10 = 0; o5 = 0; o10 = 0;
    reset = 0;
    repeat (3) step();
    reset = 1;
  endtask
  initial begin
    do_reset();
    check("rst_code", code, 0);
    check("rst_valid", valid, 0);
    check("rst_reject", rej, 0);
    check("rst_jam", jam, 0);
    check("rst_busy", busy, 0);
    check("rst_ov_code", ocode, 0);
    c5 = 1;
    for (int k = 0; k < 20; k++) begin
      step();
      check("clean_code", code, k == 7 ? 5 : 0);
      check("clean_valid", valid, k == 7);
      check("clean_reject", rej, 0);
      check("clean_busy", busy, k >= 6 && k <= 8);
    end
    do_reset();
    for (int k = 0; k < 20; k++) begin
      c10 = (k < 10) && (k % 2 == 0);
      step();
      check("bounce_code", code, 0);
      check("bounce_valid", valid, 0);
    end
    do_reset();
    n5 = 0; n10 = 0;
    for (int k = 0; k < 30; k++) begin
      c10 = (k < 6) ? (k % 2 == 0) : 1'b1;
      step();
      if (code == 4'b1010) n10++;
      if (code == 4'b0101) n5++;
    end
    check("settle_n10", n10, 1);
    check("settle_n5", n5, 0);
    do_reset();
    c5 = 1; c10 = 1;
    for (int k = 0; k < 20; k++) begin
      step();
      check("simul_code", code, k == 7 ? 5 : (k == 10 ? 10 : 0));
      check("simul_valid", valid, k == 7 || k == 10);
      check("simul_reject", rej, 0);
    end
    do_reset();
    c5 = 1;
    for (int k = 0; k < 100; k++) begin
      step();
      check("jam_code", code, k == 7 ? 5 : 0);
      if (k == 69) check("jam_early", jam, 0);
      if (k == 70) check("jam_set", jam, 1);
    end
    c5 = 0;
    repeat (10) step();
    c5 = 1; n5 = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (code == 4'b0101) n5++;
    end
    check("jam_ignored", n5, 0);
    check("jam_sticky", jam, 1);
    c5 = 0; c10 = 1;
    for (int k = 0; k < 9; k++) begin
      step();
      check("jam10_code", code, k == 7 ? 10 : 0);
    end
    check("gap_busy", busy, 1);
    check("gap_jam", jam, 1);
    reset = 0;
    #1;
    check("arst_jam", jam, 0);
    check("arst_busy", busy, 0);
    check("arst_code", code, 0);
    do_reset();
    c10 = 1;
    for (int k = 0; k < 8; k++) step();
    check("emit_code", code, 10);
    reset = 0;
    #1;
    check("emit_arst_code", code, 0);
    check("emit_arst_valid", valid, 0);
    do_reset();
    for (int k = 0; k < 45; k++) begin
      o5 = (k < 24) && (k % 8 < 4);
      step();
      check("ov_code", ocode, (k == 7 || k == 29) ? 5 : 0);
      check("ov_reject", orej, k == 22);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
